// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Multi-cycle MUL/MULHU/DIVU/REMU sequencer that borrows the shared
//            ALU for one add/subtract per cycle. Define MULDIV_SIGNED_EN to
//            add MULH/MULHSU/DIV/REM.
// Revision : 1.0
// ============================================================================
module muldiv_seq #(
    parameter int                      WIDTH      = 32,
    parameter int                      CNT_W      = 5,
    parameter int                      ALU_CTRL_W = 4,
    parameter logic [ALU_CTRL_W-1:0]   ALU_ADD    = ALU_CTRL_W'(0),
    parameter logic [ALU_CTRL_W-1:0]   ALU_SUB    = ALU_CTRL_W'(1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [WIDTH-1:0]      a_i,
    input  logic [WIDTH-1:0]      b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      result_o,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic [WIDTH-1:0]      alu_src1_o,
    output logic [WIDTH-1:0]      alu_src2_o,
    input  logic [WIDTH-1:0]      alu_result_i
);

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_hi;      // acc_hi (multiply) / remainder (divide)
    logic [WIDTH-1:0]   r_lo;      // acc_lo (multiply) / quotient (divide)
    logic [WIDTH-1:0]   r_opnd;    // multiplicand / divisor
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_neg;

    logic               w_signed;
`ifdef MULDIV_SIGNED_EN
    assign w_signed = op_i[2];
`else
    logic               w_unused_op;
    assign w_unused_op = op_i[2];
    assign w_signed    = 1'b0;
`endif

    // Signed operands become magnitudes here; the sign is reapplied on the final load.
    logic               w_a_neg, w_b_neg, w_res_neg, w_div0;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    assign w_a_neg   = w_signed & a_i[WIDTH-1];
    assign w_b_neg   = w_signed & (op_i[1] | ~op_i[0]) & b_i[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -a_i : a_i;
    assign w_b_mag   = w_b_neg ? -b_i : b_i;
    assign w_res_neg = (op_i[1] & op_i[0]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div0    = op_i[1] & (b_i == '0);

    logic               w_is_div;
    logic [WIDTH:0]     w_sh;
    logic               w_ge, w_carry;
    logic [WIDTH-1:0]   w_sum, w_hi_nxt, w_lo_nxt, w_raw, w_fin, w_prod_neg_hi;

    assign w_is_div = r_op[1];
    assign w_sh     = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = w_sh[WIDTH] | (w_sh[WIDTH-1:0] >= r_opnd);
    assign w_sum    = r_lo[0] ? alu_result_i : r_hi;
    assign w_carry  = r_lo[0] & (alu_result_i < r_hi);

    assign w_hi_nxt = w_is_div ? (w_ge ? alu_result_i : w_sh[WIDTH-1:0])
                               : {w_carry, w_sum[WIDTH-1:1]};
    assign w_lo_nxt = w_is_div ? {r_lo[WIDTH-2:0], w_ge}
                               : {w_sum[0], r_lo[WIDTH-1:1]};

    // High word of the negated 64-bit product: ~hi plus the borrow out of -lo.
    assign w_prod_neg_hi = ~w_hi_nxt + {{(WIDTH-1){1'b0}}, (w_lo_nxt == '0)};

    always_comb begin
        w_raw = '0;
        w_fin = '0;
        if (w_is_div) begin
            w_raw = r_op[0] ? w_hi_nxt : w_lo_nxt;
            w_fin = r_neg ? -w_raw : w_raw;
        end else if (r_op[0] | r_op[2]) begin
            w_fin = r_neg ? w_prod_neg_hi : w_hi_nxt;
        end else begin
            w_fin = w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        alu_ctrl_o  = ALU_ADD;
        alu_src1_o  = '0;
        alu_src2_o  = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = w_div0 ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                busy_o     = 1'b1;
                alu_ctrl_o = w_is_div ? ALU_SUB : ALU_ADD;
                alu_src1_o = w_is_div ? w_sh[WIDTH-1:0] : r_hi;
                alu_src2_o = r_opnd;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            result_o <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op  <= {w_signed, op_i[1:0]};
                        r_neg <= w_res_neg;
                        r_cnt <= '0;
                        r_hi  <= '0;
                        if (op_i[1]) begin
                            r_lo   <= w_a_mag;
                            r_opnd <= w_b_mag;
                        end else begin
                            r_lo   <= w_b_mag;
                            r_opnd <= w_a_mag;
                        end
                        if (w_div0) begin
                            result_o <= op_i[0] ? a_i : '1;
                        end
                    end
                end
                S_ITER: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        result_o <= w_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Directed bench for muldiv_seq with a behavioural ALU and an
//            arithmetic reference model checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;

    localparam logic [3:0] c_ADD = 4'd0;
    localparam logic [3:0] c_SUB = 4'd1;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result, alu_s1, alu_s2, alu_res;
    logic [3:0]  alu_ctrl;

    muldiv_seq #(
        .WIDTH(32), .CNT_W(5), .ALU_CTRL_W(4), .ALU_ADD(c_ADD), .ALU_SUB(c_SUB)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .result_o(result),
        .alu_ctrl_o(alu_ctrl), .alu_src1_o(alu_s1), .alu_src2_o(alu_s2),
        .alu_result_i(alu_res)
    );

    assign alu_res = (alu_ctrl == c_SUB) ? (alu_s1 - alu_s2) : (alu_s1 + alu_s2);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the ISA definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] opc, input logic [31:0] x,
                                               input logic [31:0] y);
        logic [63:0] p;
        logic [2:0]  o;
        longint      sx, sy;
        logic [31:0] r;
        o = opc;
`ifndef MULDIV_SIGNED_EN
        o[2] = 1'b0;
`endif
        r = '0;
        case (o)
            3'b000: begin p = 64'(x) * 64'(y); r = p[31:0];  end
            3'b001: begin p = 64'(x) * 64'(y); r = p[63:32]; end
            3'b010: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b011: r = (y == 0) ? x : x % y;
            3'b100: begin
                sx = longint'($signed(x)); sy = longint'($signed(y));
                p = sx * sy; r = p[63:32];
            end
            3'b101: begin
                sx = longint'($signed(x)); sy = longint'({32'd0, y});
                p = sx * sy; r = p[63:32];
            end
            3'b110: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(x) / $signed(y);
            end
            default: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(x) % $signed(y);
            end
        endcase
        return r;
    endfunction

    // Timeline model: cycles remaining until idle, plus the result register view.
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_res  = '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend = ref_result(op, a, b);
                m_left = (op[1] && b == 0) ? 1 : 33;
                if (m_left == 1) m_res = m_pend;
            end
        end else begin
            m_left--;
            if (m_left == 1) m_res = m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("done", {31'd0, done}, {31'd0, (m_left == 1)});
            check("result", result, m_res);
            if (m_left == 0 || m_left == 1) begin
                check("alu_ctrl_idle", {28'd0, alu_ctrl}, {28'd0, c_ADD});
                check("alu_src1_idle", alu_s1, 32'd0);
                check("alu_src2_idle", alu_s2, 32'd0);
            end
        end
    end

    task automatic run(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int lat);
        int  cyc;
        bit  got;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 45) begin
            if (done === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done_o within %0d cycles, expected at %0d", name, cyc, lat);
        end else begin
            check({name, "_res"}, result, exp);
            check({name, "_lat"}, 32'(cyc), 32'(lat));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;

        run("mul_7x6",    3'b000, 32'd7, 32'd6, 32'd42, 33);
        run("mul_ff",     3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run("mulhu_ff",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhu_mix",  3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 33);
        run("divu_100_7", 3'b010, 32'd100, 32'd7, 32'd14, 33);
        run("remu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 33);
        run("divu_big",   3'b010, 32'h8000_0000, 32'd1, 32'h8000_0000, 33);
        run("remu_big",   3'b011, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 33);
        run("divu_0",     3'b010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("remu_0",     3'b011, 32'd5, 32'd0, 32'd5, 1);

        // Abort: restart ignored at cycle 5, reset at cycle 10.
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        run("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

`ifdef MULDIV_SIGNED_EN
        run("div_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem_m7_2",   3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("mulh_m1m1",  3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33);
        run("mulhsu_m1",  3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run("div_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run("rem_ovf",    3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run("div_0",      3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem_0",      3'b111, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
`else
        run("op6_as_divu", 3'b110, 32'd100, 32'd7, 32'd14, 33);
        run("op4_as_mul",  3'b100, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
